// File: rtl/cache_controller.sv
// cache_controller: control FSM for a set-associative cache datapath.
// Sequences tag check, LRU update, write-hit merge, dirty writeback and
// line fill. It holds no line data; it only drives strobes and handshakes.
//
// Optional build macro: CACHE_PERF_CNT_EN adds hit_count/miss_count.
//
// Handshake semantics (both sides): a request (upstream_read/write,
// downstream_read/write) is a level held by its owner until the matching
// resp pulse is sampled high on a rising edge; resp is a single-cycle
// pulse that completes exactly one request and is ignored when no request
// is outstanding.
//
// fsm_state is a debug view of the state register
// (IDLE=0, LOOKUP=1, CHECK=2, WB=3, FILL=4, REFILL=5).
module cache_controller #(
  parameter int s_way  = 2,
  parameter int s_perf = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upstream_read,
  input  logic              upstream_write,
  output logic              upstream_resp,
  output logic              downstream_read,
  output logic              downstream_write,
  input  logic              downstream_resp,
  input  logic              hit,
  input  logic              valid,
  input  logic              dirty,
  output logic              cache_read,
  output logic              cache_load_en,
  output logic              downstream_address_sel,
  output logic              ld_wb,
  output logic              ld_LRU,
  output logic              new_dirty,
`ifdef CACHE_PERF_CNT_EN
  output logic [s_perf-1:0] hit_count,
  output logic [s_perf-1:0] miss_count,
`endif
  output logic [2:0]        fsm_state
);

  // The FSM is associativity-agnostic; the parameters are only range-checked.
  if (s_way < 0 || s_way > 16 || s_perf < 1) begin : g_bad_param
    $error("cache_controller: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_CHECK  = 3'd2,
    S_WB     = 3'd3,
    S_FILL   = 3'd4,
    S_REFILL = 3'd5
  } state_t;

  state_t state, state_next;

  assign fsm_state = state;

  // State register; reset drops any outstanding downstream request at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode; a write wins when both requests are high.
  always_comb begin
    state_next             = state;
    upstream_resp          = 1'b0;
    downstream_read        = 1'b0;
    downstream_write       = 1'b0;
    cache_read             = 1'b0;
    cache_load_en          = 1'b0;
    downstream_address_sel = 1'b0;
    ld_wb                  = 1'b0;
    ld_LRU                 = 1'b0;
    new_dirty              = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (upstream_read || upstream_write) begin
          state_next = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        cache_read = 1'b1;
        state_next = S_CHECK;
      end
      S_CHECK: begin
        cache_read = 1'b1;
        if (hit) begin
          ld_LRU        = 1'b1;
          upstream_resp = 1'b1;
          if (upstream_write) begin
            cache_load_en = 1'b1;
            new_dirty     = 1'b1;
          end
          state_next = S_IDLE;
        end else if (valid && dirty) begin
          ld_wb      = 1'b1;
          state_next = S_WB;
        end else begin
          state_next = S_FILL;
        end
      end
      S_WB: begin
        downstream_write       = 1'b1;
        downstream_address_sel = 1'b1;
        if (downstream_resp) begin
          state_next = S_FILL;
        end
      end
      S_FILL: begin
        downstream_read = 1'b1;
        if (downstream_resp) begin
          cache_load_en = 1'b1;
          new_dirty     = 1'b0;
          state_next    = S_REFILL;
        end
      end
      S_REFILL: begin
        cache_read = 1'b1;
        state_next = S_CHECK;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  logic from_lookup;

  // Remember whether CHECK was entered from LOOKUP so REFILL hits are not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      from_lookup <= 1'b0;
    end else begin
      from_lookup <= (state == S_LOOKUP);
    end
  end

  // Hit/miss counters, wrapping naturally at 2^s_perf.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == S_CHECK) begin
      if (hit && from_lookup) begin
        hit_count <= hit_count + 1'b1;
      end
      if (!hit) begin
        miss_count <= miss_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed, self-checking bench for cache_controller.
// Each request is described by its outcome (hit/clean/dirty miss and the
// downstream wait lengths); the bench expands that into the per-cycle
// input drive and the per-cycle expected strobes, and a single compare
// process checks the DUT against it every cycle. Build with
// CACHE_PERF_CNT_EN defined to also check the counters.
module tb_cache_controller;

`ifdef CACHE_PERF_CNT_EN
  localparam int P = 4;
`else
  localparam int P = 32;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic upstream_read = 1'b0, upstream_write = 1'b0, downstream_resp = 1'b0;
  logic hit = 1'b0, valid = 1'b0, dirty = 1'b0;
  logic upstream_resp, downstream_read, downstream_write, cache_read;
  logic cache_load_en, downstream_address_sel, ld_wb, ld_LRU, new_dirty;
  logic [2:0] fsm_state;
`ifdef CACHE_PERF_CNT_EN
  logic [P-1:0] hit_count, miss_count;
`endif

  cache_controller #(.s_way(2), .s_perf(P)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .upstream_read          (upstream_read),
    .upstream_write         (upstream_write),
    .upstream_resp          (upstream_resp),
    .downstream_read        (downstream_read),
    .downstream_write       (downstream_write),
    .downstream_resp        (downstream_resp),
    .hit                    (hit),
    .valid                  (valid),
    .dirty                  (dirty),
    .cache_read             (cache_read),
    .cache_load_en          (cache_load_en),
    .downstream_address_sel (downstream_address_sel),
    .ld_wb                  (ld_wb),
    .ld_LRU                 (ld_LRU),
    .new_dirty              (new_dirty),
`ifdef CACHE_PERF_CNT_EN
    .hit_count              (hit_count),
    .miss_count             (miss_count),
`endif
    .fsm_state              (fsm_state)
  );

  // Observed strobes packed in a fixed order:
  // {upstream_resp, downstream_read, downstream_write, cache_read,
  //  cache_load_en, downstream_address_sel, ld_wb, ld_LRU, new_dirty}
  logic [8:0] act_w;
  assign act_w = {upstream_resp, downstream_read, downstream_write, cache_read,
                  cache_load_en, downstream_address_sel, ld_wb, ld_LRU, new_dirty};

  typedef struct {
    logic [8:0] w;    // expected strobes this cycle
    int         idx;  // cycle index within the request (0 = request seen in IDLE)
    int         lat;  // hand-computed cycle index of upstream_resp, -1 if none
    bit         st;   // also require the FSM to read back as IDLE
    bit         pf;   // also check the performance counters
    longint     eh;
    longint     em;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  longint m_hit = 0;
  longint m_miss = 0;

  function automatic logic [8:0] ow(input logic ur, dr, dw, cr, cle, das, ldwb, ldlru, nd);
    return {ur, dr, dw, cr, cle, das, ldwb, ldlru, nd};
  endfunction

  function automatic logic jnk();
    return logic'($urandom_range(0, 1));
  endfunction

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic r, rd, wr, h, v, d, dr,
                             input logic [8:0] w, input int idx, input int lat,
                             input bit st, input bit pf);
    exp_t e;
    @(posedge clk);
    #1;
    rst             = r;
    upstream_read   = rd;
    upstream_write  = wr;
    hit             = h;
    valid           = v;
    dirty           = d;
    downstream_resp = dr;
    e.w = w; e.idx = idx; e.lat = lat; e.st = st; e.pf = pf;
    e.eh = m_hit; e.em = m_miss;
    exp_q.push_back(e);
  endtask

  // A cycle with no request; a stray downstream_resp must be ignored.
  task automatic gap(input bit pf);
    drive_cycle(1'b0, 1'b0, 1'b0, jnk(), jnk(), jnk(), 1'b1, 9'd0, -1, -1, 1'b1, pf);
  endtask

  // One full request. Outcome: res = line resident; v/d = victim state on a miss.
  // wbw/fw = cycles downstream waits before its resp pulse. lat = hand-computed
  // cycle of upstream_resp counting the IDLE cycle as 0.
  task automatic run_vec(input logic rd, wr, res, v, d, input int wbw, fw, lat);
    int i;
    logic dv;
    drive_cycle(1'b0, rd, wr, jnk(), jnk(), jnk(), jnk(), 9'd0, 0, lat, 1'b0, 1'b0);
    drive_cycle(1'b0, rd, wr, jnk(), jnk(), jnk(), jnk(),
                ow(0, 0, 0, 1, 0, 0, 0, 0, 0), 1, lat, 1'b0, 1'b0);
    if (res) begin
      m_hit = (m_hit + 1) % (longint'(1) << P);
      drive_cycle(1'b0, rd, wr, 1'b1, jnk(), jnk(), jnk(),
                  ow(1, 0, 0, 1, wr, 0, 0, 1, wr), 2, lat, 1'b0, 1'b0);
    end else begin
      m_miss = (m_miss + 1) % (longint'(1) << P);
      dv = v & d;
      drive_cycle(1'b0, rd, wr, 1'b0, v, d, jnk(),
                  ow(0, 0, 0, 1, 0, 0, dv, 0, 0), 2, lat, 1'b0, 1'b0);
      i = 3;
      if (dv) begin
        for (int k = 0; k <= wbw; k++) begin
          drive_cycle(1'b0, rd, wr, jnk(), jnk(), jnk(), logic'(k == wbw),
                      ow(0, 0, 1, 0, 0, 1, 0, 0, 0), i, lat, 1'b0, 1'b0);
          i = i + 1;
        end
      end
      for (int k = 0; k <= fw; k++) begin
        drive_cycle(1'b0, rd, wr, jnk(), jnk(), jnk(), logic'(k == fw),
                    ow(0, 1, 0, 0, logic'(k == fw), 0, 0, 0, 0), i, lat, 1'b0, 1'b0);
        i = i + 1;
      end
      drive_cycle(1'b0, rd, wr, jnk(), jnk(), jnk(), jnk(),
                  ow(0, 0, 0, 1, 0, 0, 0, 0, 0), i, lat, 1'b0, 1'b0);
      i = i + 1;
      drive_cycle(1'b0, rd, wr, 1'b1, 1'b1, jnk(), jnk(),
                  ow(1, 0, 0, 1, wr, 0, 0, 1, wr), i, lat, 1'b0, 1'b0);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (act_w !== e.w) begin
        n_err++;
        $display("FAIL strobes idx=%0d got=%b want=%b (resp,dr,dw,crd,ld,asel,wb,lru,nd)",
                 e.idx, act_w, e.w);
      end
      if (downstream_read === 1'b1 && downstream_write === 1'b1) begin
        n_err++;
        $display("FAIL ds_overlap idx=%0d got both high want at most one", e.idx);
      end
      if (upstream_resp === 1'b1) begin
        n_vec++;
        if (e.idx != e.lat) begin
          n_err++;
          $display("FAIL resp_latency got cycle %0d want cycle %0d", e.idx, e.lat);
        end
      end
      if (e.st) begin
        n_vec++;
        if (fsm_state !== 3'd0) begin
          n_err++;
          $display("FAIL fsm_idle got state=%0d want 0", fsm_state);
        end
      end
`ifdef CACHE_PERF_CNT_EN
      if (e.pf) begin
        n_vec++;
        if (hit_count !== e.eh[P-1:0] || miss_count !== e.em[P-1:0]) begin
          n_err++;
          $display("FAIL perf_counts got hit=%0d miss=%0d want hit=%0d miss=%0d",
                   hit_count, miss_count, e.eh, e.em);
        end
      end
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset held over two edges: every strobe 0, FSM idle, counters 0.
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, -1, -1, 1'b1, 1'b1);
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 9'd0, -1, -1, 1'b1, 1'b1);

    //      rd    wr    res   v     d     wbw fw lat
    run_vec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0,  0, 2);  // read hit
    gap(1'b0);
    run_vec(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0,  0, 2);  // write hit: merge, dirty
    gap(1'b0);
    run_vec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0,  0, 2);  // both asserted -> write
    gap(1'b0);
    run_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,  4, 9);  // clean miss, invalid set
    gap(1'b0);
    run_vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0,  0, 5);  // clean miss, valid victim
    gap(1'b0);
    run_vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2,  1, 9);  // evict the dirtied line
    gap(1'b0);
    run_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0,  0, 5);  // dirty but invalid -> clean
    run_vec(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0,  0, 6);  // back-to-back write dirty miss
    gap(1'b0);
    run_vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0,  3, 9);  // dirty miss, long fill
    gap(1'b1);                                         // counters: 3 hits, 6 misses

`ifdef CACHE_PERF_CNT_EN
    // Push miss_count round to wrap back to 0.
    for (int k = 0; k < 16 && m_miss != 0; k++) begin
      run_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 5);
    end
    gap(1'b1);
`endif

    // Reset mid-FILL: request into FILL, then raise rst between edges.
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 0, -1, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                ow(0, 0, 0, 1, 0, 0, 0, 0, 0), 1, -1, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                ow(0, 0, 0, 1, 0, 0, 0, 0, 0), 2, -1, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                ow(0, 1, 0, 0, 0, 0, 0, 0, 0), 3, -1, 1'b0, 1'b0);
    m_hit  = 0;
    m_miss = 0;
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 4, -1, 1'b1, 1'b1);
    // Late downstream_resp after reset release: no effect.
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'd0, 5, -1, 1'b1, 1'b0);
    gap(1'b0);
    gap(1'b1);

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
